utf8_decode_sequencer: RTL and testbench
========================================

Name: utf8_decode_sequencer

Overview:
Controller that sequences the hardware UTF-8 codec core in decode direction. It accepts a valid/ready byte stream, writes bytes into the codec, detects character completion or error, and reads the 32-bit code point back out big-endian. It emits one code point per character on a valid/ready output. Error sequences are replaced by a configurable replacement character, and rejected bytes are replayed into a fresh sequence.

Parameters:
REPLACEMENT, 32'h0000FFFD, code point emitted for any malformed sequence
STAT_W, 16, width of optional statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_chk_range  in  1  passed to codec range check; sampled only in FEED
s_byte  in  8  UTF-8 input byte
s_valid  in  1  input byte valid
s_ready  out  1  sequencer accepts byte
m_char  out  32  decoded code point
m_err  out  1  m_char is REPLACEMENT due to malformed input
m_valid  out  1  output valid
m_ready  in  1  downstream accepts
cdc_din  out  8  byte to codec
cdc_bin_n  out  1  codec byte-write strobe, active low, idle high
cdc_cout_n  out  1  codec char-byte-read strobe, active low, idle high
cdc_cbe  out  1  codec char endianness; tied 1 (big-endian)
cdc_chk_range  out  1  codec range check enable
cdc_rst_in  out  1  codec input-side reset
cdc_dout  in  8  codec char byte out
cdc_ready  in  1  codec: complete character available
cdc_retry  in  1  codec: last byte rejected, must be resubmitted after reset
cdc_error  in  1  codec: sequence malformed (invalid/overlong/non-Unicode)

Behaviour:
- States: FEED, WRITE, CHECK, READ, EMIT, ERR, CLR. Reset state: FEED.
- Reset values: s_ready=0 while rst high, m_valid=0, m_err=0, m_char=0, cdc_bin_n=1, cdc_cout_n=1, replay=0, hold=0, rd_cnt=0. cdc_rst_in=1 while rst high.
- FEED: s_ready=1. On s_valid&s_ready, latch s_byte into hold and go to WRITE. cfg_chk_range is latched to cdc_chk_range only in FEED.
- WRITE (1 cycle): cdc_din=hold, cdc_bin_n=0; then CHECK.
- CHECK (1 cycle, codec status settles). Priority:
  - cdc_ready -> READ with rd_cnt=0.
  - else cdc_retry -> ERR, replay=1.
  - else cdc_error -> ERR, replay=0.
  - else -> FEED.
- READ (4 cycles): cdc_cout_n=0. Each cycle m_char <= {m_char[23:0], cdc_dout}. rd_cnt increments 0..3, then EMIT.
- ERR (1 cycle): m_char<=REPLACEMENT, m_err<=1; then EMIT.
- EMIT: m_valid=1. m_char and m_err stay stable until m_valid&m_ready, then CLR. Backpressure may stall indefinitely; s_ready=0 throughout.
- CLR (1 cycle): cdc_rst_in=1, m_valid=0, m_err=0.
  - replay=1 -> clear replay, go to WRITE (hold reused, no new handshake).
  - else -> FEED.
- Latency:
  - Single-byte char: handshake at T; m_valid rises at T+7.
  - Non-final byte: s_ready high again at T+3.
  - After output handshake at E: s_ready high at E+2.
- Throughput: at most one byte in flight; no input accepted outside FEED.
- cdc_din=hold in all states; strobes are only ever low in WRITE and READ respectively, never both.
- Async reset mid-READ or mid-EMIT: partial m_char is discarded, m_valid drops immediately, and the codec is reset through cdc_rst_in.

Optional Feature:
UTF8SEQ_STATS_EN: adds outputs stat_chars[STAT_W-1:0] and stat_errs[STAT_W-1:0], both reset to 0.
- stat_chars increments on every m_valid&m_ready.
- stat_errs increments on the handshakes where m_err=1.
- Both saturate at all-ones (no wrap).
Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Byte 0x41, m_ready=1 -> m_char=0x00000041, m_err=0, m_valid at T+7; exactly 4 cdc_cout_n low cycles; one cdc_rst_in pulse after.
- Bytes E2 82 AC back-to-back -> s_ready low 2 cycles after each byte; single output m_char=0x000020AC, m_err=0.
- Overlong C0 AF (codec asserts cdc_error) -> one output m_char=0x0000FFFD, m_err=1; no replay; next byte 0x42 -> 0x00000042.
- Truncated E2 41 (codec asserts cdc_retry on 0x41) -> output 0x0000FFFD/m_err=1, then 0x41 replayed without a new s_valid, then 0x00000041/m_err=0.
- m_ready held 0 for 20 cycles during EMIT -> m_char stable, s_ready=0, no codec strobes; release -> exactly one handshake.
- rst pulsed during READ (rd_cnt=2) -> m_valid=0 and cdc_rst_in=1 immediately; after release, state FEED and 0x41 decodes normally. With UTF8SEQ_STATS_EN: stat_chars=0 after reset.

Source files
------------

// File: rtl/utf8_decode_sequencer.sv
// rtl/utf8_decode_sequencer.sv - Sequences a UTF-8 codec core in decode direction; optional stats via UTF8SEQ_STATS_EN
module utf8_decode_sequencer #(
    parameter logic [31:0] REPLACEMENT = 32'h0000FFFD,
    parameter int          STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_chk_range,
    input  logic [7:0]        s_byte,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [31:0]       m_char,
    output logic              m_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        cdc_din,
    output logic              cdc_bin_n,
    output logic              cdc_cout_n,
    output logic              cdc_cbe,
    output logic              cdc_chk_range,
    output logic              cdc_rst_in,
    input  logic [7:0]        cdc_dout,
    input  logic              cdc_ready,
    input  logic              cdc_retry,
    input  logic              cdc_error
`ifdef UTF8SEQ_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_chars,
    output logic [STAT_W-1:0] stat_errs
`endif
);

    localparam logic [2:0] FEED  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] EMIT  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;
    localparam logic [2:0] CLR   = 3'd6;

    logic [2:0] state;
    logic [7:0] hold;
    logic       replay;
    logic [1:0] rd_cnt;

    // Strobes and handshakes decode straight from the registered state so
    // they change only on clock edges and drop at once on reset.
    assign s_ready    = (state == FEED) & ~rst;
    assign m_valid    = (state == EMIT);
    assign cdc_bin_n  = ~(state == WRITE);
    assign cdc_cout_n = ~(state == READ);
    assign cdc_rst_in = rst | (state == CLR);
    assign cdc_din    = hold;
    assign cdc_cbe    = 1'b1;

    // Main sequencer: one byte in flight, status check, big-endian readout, emit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FEED;
            hold          <= 8'h00;
            replay        <= 1'b0;
            rd_cnt        <= 2'd0;
            m_char        <= 32'h0;
            m_err         <= 1'b0;
            cdc_chk_range <= 1'b0;
        end else begin
            case (state)
                FEED: begin
                    cdc_chk_range <= cfg_chk_range;
                    if (s_valid) begin
                        hold  <= s_byte;
                        state <= WRITE;
                    end
                end
                WRITE: state <= CHECK;
                CHECK: begin
                    if (cdc_ready) begin
                        rd_cnt <= 2'd0;
                        state  <= READ;
                    end else if (cdc_retry) begin
                        replay <= 1'b1;
                        state  <= ERR;
                    end else if (cdc_error) begin
                        replay <= 1'b0;
                        state  <= ERR;
                    end else begin
                        state <= FEED;
                    end
                end
                READ: begin
                    m_char <= {m_char[23:0], cdc_dout};
                    rd_cnt <= rd_cnt + 2'd1;
                    if (rd_cnt == 2'd3) begin
                        state <= EMIT;
                    end
                end
                ERR: begin
                    m_char <= REPLACEMENT;
                    m_err  <= 1'b1;
                    state  <= EMIT;
                end
                EMIT: begin
                    if (m_ready) begin
                        state <= CLR;
                    end
                end
                CLR: begin
                    m_err <= 1'b0;
                    if (replay) begin
                        // The rejected byte is still in hold; resubmit it to the freshly reset codec.
                        replay <= 1'b0;
                        state  <= WRITE;
                    end else begin
                        state <= FEED;
                    end
                end
                default: state <= FEED;
            endcase
        end
    end

`ifdef UTF8SEQ_STATS_EN
    // Saturating counters of emitted characters and of replacement characters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_chars <= '0;
            stat_errs  <= '0;
        end else if ((state == EMIT) && m_ready) begin
            if (stat_chars != {STAT_W{1'b1}}) begin
                stat_chars <= stat_chars + 1'b1;
            end
            if (m_err && (stat_errs != {STAT_W{1'b1}})) begin
                stat_errs <= stat_errs + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_utf8_decode_sequencer.sv
// tb/tb_utf8_decode_sequencer.sv - Scoreboard bench for utf8_decode_sequencer with a behavioural codec
module tb_utf8_decode_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_chk_range = 1'b0;
    logic [7:0]  s_byte = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_char;
    logic        m_err;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  cdc_din;
    logic        cdc_bin_n;
    logic        cdc_cout_n;
    logic        cdc_cbe;
    logic        cdc_chk_range;
    logic        cdc_rst_in;
    logic [7:0]  cdc_dout;
    logic        cdc_ready;
    logic        cdc_retry;
    logic        cdc_error;
`ifdef UTF8SEQ_STATS_EN
    logic [15:0] stat_chars;
    logic [15:0] stat_errs;
`endif

    utf8_decode_sequencer dut (
        .clk(clk), .rst(rst), .cfg_chk_range(cfg_chk_range),
        .s_byte(s_byte), .s_valid(s_valid), .s_ready(s_ready),
        .m_char(m_char), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready),
        .cdc_din(cdc_din), .cdc_bin_n(cdc_bin_n), .cdc_cout_n(cdc_cout_n),
        .cdc_cbe(cdc_cbe), .cdc_chk_range(cdc_chk_range), .cdc_rst_in(cdc_rst_in),
        .cdc_dout(cdc_dout), .cdc_ready(cdc_ready), .cdc_retry(cdc_retry),
        .cdc_error(cdc_error)
`ifdef UTF8SEQ_STATS_EN
        , .stat_chars(stat_chars), .stat_errs(stat_errs)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural codec ----------------
    logic [31:0] c_acc;
    int          c_need, c_len;
    logic [1:0]  c_idx;

    assign cdc_dout = (c_idx == 2'd0) ? c_acc[31:24] :
                      (c_idx == 2'd1) ? c_acc[23:16] :
                      (c_idx == 2'd2) ? c_acc[15:8]  : c_acc[7:0];

    always @(posedge clk) begin : codec
        logic [31:0] acc;
        logic        bad;
        if (cdc_rst_in) begin
            c_acc <= 0; c_need <= 0; c_len <= 0; c_idx <= 0;
            cdc_ready <= 0; cdc_retry <= 0; cdc_error <= 0;
        end else begin
            if (!cdc_cout_n) c_idx <= c_idx + 2'd1;
            if (!cdc_bin_n) begin
                if (c_need == 0) begin
                    if (cdc_din < 8'h80) begin
                        c_acc <= {24'h0, cdc_din}; cdc_ready <= 1;
                    end else if (cdc_din < 8'hC0 || cdc_din >= 8'hF8) begin
                        cdc_error <= 1;
                    end else if (cdc_din >= 8'hF0) begin
                        c_acc <= {29'h0, cdc_din[2:0]}; c_need <= 3; c_len <= 4;
                    end else if (cdc_din >= 8'hE0) begin
                        c_acc <= {28'h0, cdc_din[3:0]}; c_need <= 2; c_len <= 3;
                    end else begin
                        c_acc <= {27'h0, cdc_din[4:0]}; c_need <= 1; c_len <= 2;
                    end
                end else if (cdc_din[7:6] == 2'b10) begin
                    acc = {c_acc[25:0], cdc_din[5:0]};
                    c_acc  <= acc;
                    c_need <= c_need - 1;
                    if (c_need == 1) begin
                        bad = (c_len == 2 && acc < 32'h80) || (c_len == 3 && acc < 32'h800) ||
                              (c_len == 4 && acc < 32'h10000) ||
                              (cdc_chk_range && (acc > 32'h10FFFF || (acc >= 32'hD800 && acc <= 32'hDFFF)));
                        if (bad) cdc_error <= 1;
                        else     cdc_ready <= 1;
                    end
                end else begin
                    cdc_retry <= 1;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];
    int n_cout = 0, n_rsti = 0, n_overlap = 0, n_hs = 0;
    int mv_rise = 0, e_cyc = 0, sr_cyc = 0;
    logic mv_q = 0, pend_sr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (!cdc_cout_n) n_cout++;
        if (cdc_rst_in && !rst) n_rsti++;
        if (!cdc_cout_n && !cdc_bin_n) n_overlap++;
        if (m_valid && !mv_q) mv_rise = cyc;
        mv_q = m_valid;
        if (m_valid && m_ready) begin
            n_hs++;
            e_cyc = cyc + 1;
            pend_sr = 1;
            if (sb.size() == 0) begin
                chk("unexpected_output", m_char, 32'hDEAD_BEEF);
            end else begin
                e = sb.pop_front();
                chk("out_char", m_char, e[31:0]);
                chk("out_err", {31'h0, m_err}, {31'h0, e[32]});
            end
        end else if (pend_sr && s_ready) begin
            sr_cyc = cyc + 1;
            pend_sr = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, output int t);
        int n;
        logic hs;
        s_byte = b; s_valid = 1; n = 0; hs = 0;
        while (!hs && n < 200) begin
            @(negedge clk); hs = s_ready;
            @(posedge clk); #1; n++;
        end
        s_valid = 0;
        t = cyc;
        if (!hs) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_nonfinal(input logic [7:0] b);
        int t;
        send_byte(b, t);
        chk("nf_sready_w", {31'h0, s_ready}, 32'h0);
        @(posedge clk); #1;
        chk("nf_sready_c", {31'h0, s_ready}, 32'h0);
        @(posedge clk); #1;
        chk("nf_sready_back", {31'h0, s_ready}, 32'h1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb.size() == 0 && s_ready) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) chk("idle_timeout", 32'h0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int t, c0, r0, h0, n;
        logic ok;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_m_err", {31'h0, m_err}, 32'h0);
        chk("rst_m_char", m_char, 32'h0);
        chk("rst_strobes", {30'h0, cdc_bin_n, cdc_cout_n}, 32'h3);
        chk("rst_cdc_rst_in", {31'h0, cdc_rst_in}, 32'h1);
        chk("cbe_tied", {31'h0, cdc_cbe}, 32'h1);
`ifdef UTF8SEQ_STATS_EN
        chk("rst_stat_chars", {16'h0, stat_chars}, 32'h0);
`endif
        rst = 0;
        @(posedge clk); #1;
        chk("feed_s_ready", {31'h0, s_ready}, 32'h1);

        // single ASCII byte: latency, readout count, codec reset pulse, s_ready recovery
        c0 = n_cout; r0 = n_rsti;
        sb.push_back({1'b0, 32'h00000041});
        send_byte(8'h41, t);
        wait_idle();
        chk("ascii_latency", mv_rise + 1 - t, 32'd7);
        chk("ascii_cout_cycles", n_cout - c0, 32'd4);
        chk("ascii_rst_pulses", n_rsti - r0, 32'd1);
        chk("emit_to_sready", sr_cyc - e_cyc, 32'd2);

        // three-byte euro sign
        sb.push_back({1'b0, 32'h000020AC});
        send_nonfinal(8'hE2);
        send_nonfinal(8'h82);
        send_byte(8'hAC, t);
        wait_idle();

        // overlong C0 AF, then a fresh byte
        sb.push_back({1'b1, 32'h0000FFFD});
        send_nonfinal(8'hC0);
        send_byte(8'hAF, t);
        sb.push_back({1'b0, 32'h00000042});
        send_byte(8'h42, t);
        wait_idle();

        // truncated E2 41: replacement, then 0x41 replayed without a new handshake
        sb.push_back({1'b1, 32'h0000FFFD});
        sb.push_back({1'b0, 32'h00000041});
        send_nonfinal(8'hE2);
        send_byte(8'h41, t);
        wait_idle();

        // surrogate D800 with and without range checking
        cfg_chk_range = 1;
        sb.push_back({1'b1, 32'h0000FFFD});
        send_nonfinal(8'hED); send_nonfinal(8'hA0); send_byte(8'h80, t);
        wait_idle();
        cfg_chk_range = 0;
        sb.push_back({1'b0, 32'h0000D800});
        send_nonfinal(8'hED); send_nonfinal(8'hA0); send_byte(8'h80, t);
        wait_idle();

        // backpressure during EMIT
        m_ready = 0;
        sb.push_back({1'b0, 32'h00000043});
        send_byte(8'h43, t);
        n = 0;
        while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("stall_reached_emit", {31'h0, m_valid}, 32'h1);
        ok = 1;
        repeat (20) begin
            @(posedge clk); #1;
            if (m_char !== 32'h43 || s_ready !== 1'b0 || cdc_bin_n !== 1'b1 ||
                cdc_cout_n !== 1'b1 || m_valid !== 1'b1) ok = 0;
        end
        chk("stall_stable", {31'h0, ok}, 32'h1);
        h0 = n_hs;
        m_ready = 1;
        repeat (8) @(posedge clk);
        #1;
        chk("stall_one_handshake", n_hs - h0, 32'd1);
        wait_idle();

        // async reset in the middle of READ (rd_cnt == 2)
        send_byte(8'h41, t);
        n = 0;
        while (cdc_cout_n && n < 20) begin @(posedge clk); #1; n++; end
        chk("read_reached", {31'h0, cdc_cout_n}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("midread_m_valid", {31'h0, m_valid}, 32'h0);
        chk("midread_cdc_rst_in", {31'h0, cdc_rst_in}, 32'h1);
        chk("midread_m_char", m_char, 32'h0);
        chk("midread_cout_n", {31'h0, cdc_cout_n}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_feed", {31'h0, s_ready}, 32'h1);
`ifdef UTF8SEQ_STATS_EN
        chk("post_rst_stat_chars", {16'h0, stat_chars}, 32'h0);
`endif
        sb.push_back({1'b0, 32'h00000041});
        send_byte(8'h41, t);
        wait_idle();

        chk("sb_drained", sb.size(), 32'd0);
        chk("strobe_overlap", n_overlap, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
